// File: rtl/fft_mem_pkg.sv
// fft_mem_pkg: shared FSM state types and the bit-reversal helper for the FFT ping-pong buffer
package fft_mem_pkg;
  typedef enum logic {F_FILL, F_FULL} fill_state_t;
  typedef enum logic {P_IDLE, P_BUSY} proc_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_mem_bank.sv
// fft_mem_bank: DEPTH x DATA_W memory, one sync write port, one sync read-before-write read port, no reset
//   clk        clock
//   we/wa/wd   write enable, address, data
//   ra/rd      read address, registered read data (1-cycle latency, returns old word on collision)
module fft_mem_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
    rd_q <= mem_q[ra];
  end
  assign rd = rd_q;
endmodule

// File: rtl/fft_pingpong_buffer.sv
// fft_pingpong_buffer: two-bank ping-pong buffer between the FFT input stream and the butterfly engine
//   clk, rst (async, active-low)
//   in_valid/in_data/in_ready      input stream into the fill bank (~proc_sel)
//   proc_start/proc_busy/proc_done bank hand-off handshake with the engine
//   proc_rd_*/proc_wr_*            engine port on bank proc_sel (writes only while busy)
//   proc_sel, fill_count           engine-owned bank index, samples in current fill bank
// Build option: FFT_BITREV_WR_EN stores the input stream in bit-reversed address order.
module fft_pingpong_buffer
  import fft_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              proc_start,
  output logic              proc_busy,
  input  logic              proc_done,
  input  logic [ADDR_W-1:0] proc_rd_addr,
  output logic [DATA_W-1:0] proc_rd_data,
  input  logic              proc_wr_en,
  input  logic [ADDR_W-1:0] proc_wr_addr,
  input  logic [DATA_W-1:0] proc_wr_data,
  output logic              proc_sel,
  output logic [ADDR_W:0]   fill_count
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  fill_state_t fill_state_q, fill_state_d;
  proc_state_t proc_state_q, proc_state_d;
  logic [ADDR_W:0] fill_count_q, fill_count_d;
  logic proc_sel_q, proc_sel_d, proc_start_q, proc_start_d;
  logic rd_sel_q, rd_sel_d, rd_ok_q, rd_ok_d;
  logic accept, swap;
  logic [ADDR_W-1:0] fill_addr;
  logic [1:0] we;
  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [DATA_W-1:0] rd [2];
  always_comb begin
    accept = in_valid && fill_state_q == F_FILL;
    swap = fill_state_q == F_FULL && proc_state_q == P_IDLE;
    fill_count_d = swap ? '0 : accept ? fill_count_q + 1'b1 : fill_count_q;
    fill_state_d = swap ? F_FILL : (accept && fill_count_q == LAST) ? F_FULL : fill_state_q;
    proc_state_d = swap ? P_BUSY : (proc_state_q == P_BUSY && proc_done) ? P_IDLE : proc_state_q;
    proc_sel_d = proc_sel_q ^ swap;
    proc_start_d = swap;
    // read data comes from whichever bank the engine owned when the address was sampled
    rd_sel_d = proc_sel_q;
    // holds read data at zero until the banks have produced a word since reset
    rd_ok_d = 1'b1;
`ifdef FFT_BITREV_WR_EN
    fill_addr = ADDR_W'(bitrev(32'(fill_count_q[ADDR_W-1:0]), ADDR_W));
`else
    fill_addr = fill_count_q[ADDR_W-1:0];
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_state_q <= F_FILL;
      proc_state_q <= P_IDLE;
      fill_count_q <= '0;
      proc_sel_q <= 1'b0;
      proc_start_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      proc_state_q <= proc_state_d;
      fill_count_q <= fill_count_d;
      proc_sel_q <= proc_sel_d;
      proc_start_q <= proc_start_d;
      rd_sel_q <= rd_sel_d;
      rd_ok_q <= rd_ok_d;
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = (proc_sel_q == 1'(b)) ? proc_wr_en && proc_state_q == P_BUSY : accept;
    assign wa[b] = (proc_sel_q == 1'(b)) ? proc_wr_addr : fill_addr;
    assign wd[b] = (proc_sel_q == 1'(b)) ? proc_wr_data : in_data;
    fft_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
      .clk(clk),
      .we(we[b]),
      .wa(wa[b]),
      .wd(wd[b]),
      .ra(proc_rd_addr),
      .rd(rd[b])
    );
  end
  assign in_ready = fill_state_q == F_FILL;
  assign proc_start = proc_start_q;
  assign proc_busy = proc_state_q == P_BUSY;
  assign proc_sel = proc_sel_q;
  assign fill_count = fill_count_q;
  assign proc_rd_data = rd_ok_q ? rd[rd_sel_q] : '0;
endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// tb_fft_pingpong_buffer: directed table/sequence checks plus randomized run against a behavioural model
module tb_fft_pingpong_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, proc_start, proc_busy, proc_sel;
  logic proc_done = 1'b0;
  logic [AW-1:0] proc_rd_addr = '0;
  logic [DATA_W-1:0] proc_rd_data;
  logic proc_wr_en = 1'b0;
  logic [AW-1:0] proc_wr_addr = '0;
  logic [DATA_W-1:0] proc_wr_data = '0;
  logic [AW:0] fill_count;
  int checks = 0;
  int errors = 0;
  typedef struct {int addr; int exp;} vec_t;
  vec_t vt [8];
  int mm [2][DEPTH];
  bit mk [2][DEPTH];
  int m_sel, m_cnt, m_rd;
  bit m_full, m_busy, m_start, m_rdk;

  fft_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .proc_start(proc_start), .proc_busy(proc_busy), .proc_done(proc_done),
    .proc_rd_addr(proc_rd_addr), .proc_rd_data(proc_rd_data), .proc_wr_en(proc_wr_en),
    .proc_wr_addr(proc_wr_addr), .proc_wr_data(proc_wr_data), .proc_sel(proc_sel),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int br(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // sample k of a frame lands at faddr(k); bit reversal is its own inverse
  function automatic int faddr(input int c);
`ifdef FFT_BITREV_WR_EN
    return br(c);
`else
    return c;
`endif
  endfunction

  task automatic write_frame(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      check("fill_count", fill_count, k);
      check("in_ready_fill", in_ready, 1);
      in_valid = 1'b1;
      in_data = DATA_W'(base + k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_bank(input string nm, input int base);
    for (int a = 0; a < DEPTH; a++) begin
      proc_rd_addr = AW'(a);
      tick();
      check(nm, proc_rd_data, (base + faddr(a)) & 8'hFF);
    end
  endtask

  task automatic model_step(input bit iv, input int id, input bit done, input bit we,
                            input int wa, input int wd, input int ra);
    int nr;
    bit nk, sw;
    nr = mm[m_sel][ra];
    nk = mk[m_sel][ra];
    if (we && m_busy) begin
      mm[m_sel][wa] = wd;
      mk[m_sel][wa] = 1'b1;
    end
    sw = m_full && !m_busy;
    if (iv && !m_full) begin
      mm[1-m_sel][faddr(m_cnt)] = id;
      mk[1-m_sel][faddr(m_cnt)] = 1'b1;
      m_cnt++;
      if (m_cnt == DEPTH) m_full = 1'b1;
    end
    m_start = sw;
    if (sw) begin
      m_sel = 1 - m_sel;
      m_full = 1'b0;
      m_cnt = 0;
      m_busy = 1'b1;
    end else if (m_busy && done) m_busy = 1'b0;
    m_rd = nr;
    m_rdk = nk;
  endtask

  initial begin
    int addrs [8] = '{0, 1, 6, 31, 5, 16, 12, 2};
    for (int i = 0; i < 8; i++) begin
      vt[i].addr = addrs[i];
      vt[i].exp = faddr(addrs[i]);
    end
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_start", proc_start, 0);
    check("rst_busy", proc_busy, 0);
    check("rst_sel", proc_sel, 0);
    check("rst_count", fill_count, 0);
    check("rst_rd_data", proc_rd_data, 0);
    tick();
    rst = 1'b1;
    // first frame, stream held valid
    write_frame(0, DEPTH);
    check("full_ready", in_ready, 0);
    check("full_start", proc_start, 0);
    check("full_count", fill_count, DEPTH);
    tick();
    check("swap_start", proc_start, 1);
    check("swap_sel", proc_sel, 1);
    check("swap_busy", proc_busy, 1);
    check("swap_ready", in_ready, 1);
    check("swap_count", fill_count, 0);
    tick();
    check("start_one_cycle", proc_start, 0);
    for (int i = 0; i < 8; i++) begin
      proc_rd_addr = AW'(vt[i].addr);
      tick();
      check("table_read", proc_rd_data, vt[i].exp);
    end
    read_bank("frame1_read", 0);
    // read-before-write on the proc port
    proc_wr_en = 1'b1;
    proc_wr_addr = 5'd5;
    proc_wr_data = 8'hA5;
    proc_rd_addr = 5'd5;
    tick();
    proc_wr_en = 1'b0;
    check("rbw_old", proc_rd_data, faddr(5));
    tick();
    check("rbw_new", proc_rd_data, 8'hA5);
    // second frame completes while the engine is busy
    write_frame(8'h40, DEPTH);
    for (int i = 0; i < 5; i++) begin
      check("busy_hold_ready", in_ready, 0);
      check("busy_hold_start", proc_start, 0);
      check("busy_hold_busy", proc_busy, 1);
      tick();
    end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("done_busy", proc_busy, 0);
    check("done_ready", in_ready, 0);
    check("done_start", proc_start, 0);
    tick();
    check("swap2_start", proc_start, 1);
    check("swap2_sel", proc_sel, 0);
    check("swap2_ready", in_ready, 1);
    read_bank("frame2_read", 8'h40);
    // writes while idle must not land
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("idle_busy", proc_busy, 0);
    proc_wr_en = 1'b1;
    proc_wr_addr = 5'd3;
    proc_wr_data = 8'hEE;
    proc_rd_addr = 5'd3;
    tick();
    proc_wr_en = 1'b0;
    tick();
    check("idle_write_ignored", proc_rd_data, 8'h40 + faddr(3));
    // reset mid-fill
    write_frame(8'h80, 17);
    check("partial_count", fill_count, 17);
    rst = 1'b0;
    #1;
    check("mid_rst_count", fill_count, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_busy", proc_busy, 0);
    check("mid_rst_rd_data", proc_rd_data, 0);
    check("mid_rst_sel", proc_sel, 0);
    tick();
    rst = 1'b1;
    write_frame(8'h90, DEPTH - 1);
    check("no_early_start", proc_start, 0);
    check("no_early_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = 8'h90 + 8'd31;
    tick();
    in_valid = 1'b0;
    check("post_rst_full", in_ready, 0);
    tick();
    check("post_rst_start", proc_start, 1);
    check("post_rst_sel", proc_sel, 1);
    // proc_done coincident with the last write of the next frame
    write_frame(8'hB0, DEPTH - 1);
    in_valid = 1'b1;
    in_data = 8'hB0 + 8'd31;
    proc_done = 1'b1;
    tick();
    in_valid = 1'b0;
    proc_done = 1'b0;
    check("coin_busy", proc_busy, 0);
    check("coin_ready", in_ready, 0);
    check("coin_start", proc_start, 0);
    tick();
    check("coin_swap_start", proc_start, 1);
    check("coin_swap_sel", proc_sel, 0);
    tick();
    check("coin_start_once", proc_start, 0);
    check("coin_busy2", proc_busy, 1);
    read_bank("coin_read", 8'hB0);
    check("coin_no_restart", proc_start, 0);
    // randomized run against the behavioural model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_sel = 0;
    m_cnt = 0;
    m_full = 1'b0;
    m_busy = 1'b0;
    m_start = 1'b0;
    m_rd = 0;
    m_rdk = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mk[b][a] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int id, wa, wd, ra;
      bit iv, done, we;
      iv = $urandom_range(0, 3) != 0;
      id = $urandom_range(0, 255);
      done = $urandom_range(0, 15) == 0;
      we = $urandom_range(0, 1) == 1;
      wa = $urandom_range(0, DEPTH - 1);
      wd = $urandom_range(0, 255);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
      in_valid = iv;
      in_data = DATA_W'(id);
      proc_done = done;
      proc_wr_en = we;
      proc_wr_addr = AW'(wa);
      proc_wr_data = DATA_W'(wd);
      proc_rd_addr = AW'(ra);
      check("rnd_ready", in_ready, !m_full);
      check("rnd_busy", proc_busy, m_busy);
      check("rnd_sel", proc_sel, m_sel);
      check("rnd_count", fill_count, m_cnt);
      check("rnd_start", proc_start, m_start);
      if (m_rdk) check("rnd_rd_data", proc_rd_data, m_rd);
      model_step(iv, id, done, we, wa, wd, ra);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
